// File: rtl/pkt_pkg.sv
// Shared definitions for the packet-path blocks: beat width, beat-type codes
// and the write-side FSM state encoding.
package pkt_pkg;
  localparam int PKT_W = 134;

  localparam logic [1:0] PKT_HEAD = 2'b01;
  localparam logic [1:0] PKT_BODY = 2'b00;
  localparam logic [1:0] PKT_TAIL = 2'b10;
  localparam logic [1:0] PKT_ILL  = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RECV = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// single-cycle read. Contents are not reset.
module sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/pkt_out_buffer.sv
// Store-and-forward packet buffer: absorbs unthrottled input bursts, drops
// bad or oversized packets whole, and releases committed packets on valid/ready.
module pkt_out_buffer
  import pkt_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in_valid,
  input  logic [PKT_W-1:0] data_in,
  output logic             pkt_out_valid,
  output logic [PKT_W-1:0] pkt_out,
  input  logic             pkt_out_ready,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             drop_pulse_o
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            PW       = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  wr_state_t        r_state, w_state_next;
  logic [PW-1:0]    r_wr_ptr, r_wr_commit, r_rd_ptr, w_wr_ptr_next;
  logic [AW-1:0]    w_wr_addr;
  logic             w_wr_en, w_commit, w_drop, w_full, w_commit_full;
  logic [1:0]       w_in_type;
  logic [CNT_W-1:0] r_pkt_cnt, r_drop_cnt;
  logic             r_drop_pulse;

  logic             r_rd_inflight, w_rd_en, w_pop, w_tail_out;
  logic [1:0]       r_fifo_cnt, w_fifo_cnt_next, w_occ;
  logic [PKT_W-1:0] r_fifo_d0, r_fifo_d1, w_fifo_d0_next, w_fifo_d1_next, w_ram_rd;

  assign w_in_type     = data_in[PKT_W-1 -: 2];
  assign w_full        = (r_wr_ptr - r_rd_ptr) == FULL_LVL;
  assign w_commit_full = (r_wr_commit - r_rd_ptr) == FULL_LVL;

  always_comb begin
    w_state_next  = r_state;
    w_wr_en       = 1'b0;
    w_wr_addr     = r_wr_ptr[AW-1:0];
    w_wr_ptr_next = r_wr_ptr;
    w_commit      = 1'b0;
    w_drop        = 1'b0;
    if (data_in_valid) begin
      if (w_in_type == PKT_HEAD) begin
        // Any head restarts at the committed boundary; a partial packet in RECV is dropped.
        w_wr_ptr_next = r_wr_commit;
        w_drop        = (r_state == WR_RECV);
        if (w_commit_full) begin
          w_state_next = WR_DROP;
          w_drop       = 1'b1;
        end else begin
          w_wr_en       = 1'b1;
          w_wr_addr     = r_wr_commit[AW-1:0];
          w_wr_ptr_next = r_wr_commit + PTR_ONE;
          w_state_next  = WR_RECV;
        end
      end else begin
        case (r_state)
          WR_RECV: begin
            if (w_in_type == PKT_ILL || w_full) begin
              w_state_next  = WR_DROP;
              w_wr_ptr_next = r_wr_commit;
              w_drop        = 1'b1;
            end else begin
              w_wr_en       = 1'b1;
              w_wr_ptr_next = r_wr_ptr + PTR_ONE;
              if (w_in_type == PKT_TAIL) begin
                w_commit     = 1'b1;
                w_state_next = WR_IDLE;
              end
            end
          end
          WR_DROP: if (w_in_type == PKT_TAIL) w_state_next = WR_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WR_IDLE;
      r_wr_ptr     <= '0;
      r_wr_commit  <= '0;
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wr_ptr     <= w_wr_ptr_next;
      r_drop_pulse <= w_drop;
      if (w_commit) r_wr_commit <= w_wr_ptr_next;
      if (w_drop && r_drop_cnt != {CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  sdp_ram #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_ram_rd)
  );

  // Reads in flight count against the 2-entry prefetch FIFO so it never overflows.
  assign w_pop      = (r_fifo_cnt != 2'd0) && pkt_out_ready;
  assign w_occ      = r_fifo_cnt + {1'b0, r_rd_inflight};
  assign w_rd_en    = (r_rd_ptr != r_wr_commit) && ((w_occ - {1'b0, w_pop}) < 2'd2);
  assign w_tail_out = w_pop && (r_fifo_d0[PKT_W-1 -: 2] == PKT_TAIL);

  always_comb begin
    w_fifo_d0_next  = r_fifo_d0;
    w_fifo_d1_next  = r_fifo_d1;
    w_fifo_cnt_next = r_fifo_cnt;
    if (w_pop) begin
      w_fifo_d0_next  = r_fifo_d1;
      w_fifo_cnt_next = r_fifo_cnt - 2'd1;
    end
    if (r_rd_inflight) begin
      if (w_fifo_cnt_next == 2'd0) w_fifo_d0_next = w_ram_rd;
      else                         w_fifo_d1_next = w_ram_rd;
      w_fifo_cnt_next = w_fifo_cnt_next + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr      <= '0;
      r_rd_inflight <= 1'b0;
      r_fifo_cnt    <= 2'd0;
      r_fifo_d0     <= '0;
      r_fifo_d1     <= '0;
      r_pkt_cnt     <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_rd_inflight <= w_rd_en;
      r_fifo_cnt    <= w_fifo_cnt_next;
      r_fifo_d0     <= w_fifo_d0_next;
      r_fifo_d1     <= w_fifo_d1_next;
      case ({w_commit, w_tail_out})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign pkt_out_valid = (r_fifo_cnt != 2'd0);
  assign pkt_out       = r_fifo_d0;
  assign pkt_cnt_o     = r_pkt_cnt;
  assign drop_cnt_o    = r_drop_cnt;
  assign drop_pulse_o  = r_drop_pulse;
endmodule

// File: tb/tb_pkt_out_buffer.sv
// Directed and constrained-random checks of pkt_out_buffer with a small
// in-order scoreboard of the beats expected at the output.
module tb_pkt_out_buffer;
  import pkt_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             data_in_valid = 1'b0;
  logic [PKT_W-1:0] data_in = '0;
  logic             pkt_out_ready = 1'b0;
  logic             pkt_out_valid;
  logic [PKT_W-1:0] pkt_out;
  logic [CNT_W-1:0] pkt_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             drop_pulse_o;

  pkt_out_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .pkt_out_valid (pkt_out_valid),
    .pkt_out       (pkt_out),
    .pkt_out_ready (pkt_out_ready),
    .pkt_cnt_o     (pkt_cnt_o),
    .drop_cnt_o    (drop_cnt_o),
    .drop_pulse_o  (drop_pulse_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int rx_beats = 0;
  int rx_pkts = 0;
  int cur_len = 0;
  int pulse_cnt = 0;
  int exp_drops = 0;
  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] last_pkt[$];
  logic [PKT_W-1:0] exp_beat;
  logic             prev_stall = 1'b0;
  logic [PKT_W-1:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [1:0] t, input logic [131:0] p);
    data_in       = {t, p};
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit keep);
    logic [1:0]   t;
    logic [131:0] p;
    last_pkt.delete();
    for (int i = 0; i < len; i++) begin
      t = (i == 0) ? PKT_HEAD : ((i == len - 1) ? PKT_TAIL : PKT_BODY);
      p = {$urandom(), $urandom(), $urandom(), $urandom(), 4'(i)};
      last_pkt.push_back({t, p});
      if (keep) exp_q.push_back({t, p});
      send_beat(t, p);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    repeat (4) step();
    check_eq("drain_left", PKT_W'(exp_q.size()), '0);
  endtask

  // Ready is updated once per cycle, after the edge, from the selected mode.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       pkt_out_ready = 1'b0;
      1:       pkt_out_ready = 1'b1;
      default: pkt_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      cur_len    = 0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", PKT_W'(pkt_out_valid), PKT_W'(1));
        check_eq("stall_data", pkt_out, prev_data);
      end
      if (pkt_out_valid && pkt_out_ready) begin
        check_eq("spurious_beat", PKT_W'(exp_q.size() == 0), '0);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          check_eq("out_beat", pkt_out, exp_beat);
        end
        rx_beats++;
        cur_len++;
        if (pkt_out[PKT_W-1 -: 2] == PKT_TAIL) begin
          rx_pkts++;
          $display("rx pkt %0d len=%0d t=%0t", rx_pkts, cur_len, $time);
          cur_len = 0;
        end
      end
      prev_stall = pkt_out_valid && !pkt_out_ready;
      prev_data  = pkt_out;
    end
    if (drop_pulse_o) pulse_cnt++;
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout got=%0d exp=finished", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int base_rx, base_pulse, len, n;

    // Reset values
    repeat (3) step();
    check_eq("rst_valid", PKT_W'(pkt_out_valid), '0);
    check_eq("rst_data", pkt_out, '0);
    check_eq("rst_pkt_cnt", PKT_W'(pkt_cnt_o), '0);
    check_eq("rst_drop_cnt", PKT_W'(drop_cnt_o), '0);
    check_eq("rst_pulse", PKT_W'(drop_pulse_o), '0);
    rst_n = 1'b1;
    step();

    // 1: single 4-beat packet, ready high; latency and back-to-back beats
    ready_mode = 1;
    step(); step();
    send_pkt(4, 1'b1);
    check_eq("t1_cnt_commit", PKT_W'(pkt_cnt_o), PKT_W'(1));
    check_eq("t1_valid_n0", PKT_W'(pkt_out_valid), '0);
    step();
    check_eq("t1_valid_n1", PKT_W'(pkt_out_valid), '0);
    step();
    check_eq("t1_valid_n2", PKT_W'(pkt_out_valid), PKT_W'(1));
    check_eq("t1_beat0", pkt_out, last_pkt[0]);
    for (int i = 1; i < 4; i++) begin
      step();
      check_eq("t1_beat_valid", PKT_W'(pkt_out_valid), PKT_W'(1));
      check_eq("t1_beat", pkt_out, last_pkt[i]);
    end
    check_eq("t1_cnt_before_tail", PKT_W'(pkt_cnt_o), PKT_W'(1));
    step();
    check_eq("t1_cnt_after", PKT_W'(pkt_cnt_o), '0);
    check_eq("t1_valid_after", PKT_W'(pkt_out_valid), '0);
    $display("t1 single packet done");

    // 2: ready low, second 10-beat packet overflows the 16-beat buffer
    ready_mode = 0;
    step(); step();
    base_rx = rx_beats;
    base_pulse = pulse_cnt;
    send_pkt(10, 1'b1);
    check_eq("t2_cnt_commit", PKT_W'(pkt_cnt_o), PKT_W'(1));
    send_pkt(10, 1'b0);
    exp_drops++;
    step(); step();
    check_eq("t2_drop_cnt", PKT_W'(drop_cnt_o), PKT_W'(exp_drops));
    check_eq("t2_pulses", PKT_W'(pulse_cnt - base_pulse), PKT_W'(1));
    check_eq("t2_cnt_held", PKT_W'(pkt_cnt_o), PKT_W'(1));
    check_eq("t2_no_output", PKT_W'(rx_beats - base_rx), '0);
    ready_mode = 1;
    drain(200);
    check_eq("t2_rx_beats", PKT_W'(rx_beats - base_rx), PKT_W'(10));
    $display("t2 overflow done");

    // 3: new head mid-packet drops the partial
    base_rx = rx_beats;
    base_pulse = pulse_cnt;
    send_beat(PKT_HEAD, 132'h1);
    send_beat(PKT_BODY, 132'h2);
    send_pkt(3, 1'b1);
    exp_drops++;
    drain(200);
    check_eq("t3_drop_cnt", PKT_W'(drop_cnt_o), PKT_W'(exp_drops));
    check_eq("t3_pulses", PKT_W'(pulse_cnt - base_pulse), PKT_W'(1));
    check_eq("t3_rx_beats", PKT_W'(rx_beats - base_rx), PKT_W'(3));
    $display("t3 head restart done");

    // 4: strays in IDLE ignored, illegal beat drops the packet
    base_rx = rx_beats;
    base_pulse = pulse_cnt;
    send_beat(PKT_BODY, 132'h10);
    send_beat(PKT_TAIL, 132'h11);
    step();
    check_eq("t4_stray_nocount", PKT_W'(drop_cnt_o), PKT_W'(exp_drops));
    send_beat(PKT_HEAD, 132'h20);
    send_beat(PKT_BODY, 132'h21);
    send_beat(PKT_ILL,  132'h22);
    send_beat(PKT_BODY, 132'h23);
    send_beat(PKT_TAIL, 132'h24);
    exp_drops++;
    step(); step();
    check_eq("t4_drop_cnt", PKT_W'(drop_cnt_o), PKT_W'(exp_drops));
    check_eq("t4_pulses", PKT_W'(pulse_cnt - base_pulse), PKT_W'(1));
    send_pkt(2, 1'b1);
    drain(200);
    check_eq("t4_rx_beats", PKT_W'(rx_beats - base_rx), PKT_W'(2));
    $display("t4 stray/illegal done");

    // 5: random ready, many packets crossing the pointer wrap, never overfilled
    ready_mode = 2;
    base_rx = rx_beats;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(2, 12);
      n = 0;
      while (exp_q.size() + len > DEPTH - 1 && n < 500) begin
        step();
        n++;
      end
      if (n >= 500) begin
        check_eq("t5_space_wait", PKT_W'(exp_q.size()), '0);
        break;
      end
      send_pkt(len, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end
    drain(5000);
    check_eq("t5_drop_cnt", PKT_W'(drop_cnt_o), PKT_W'(exp_drops));
    check_eq("t5_pkt_cnt", PKT_W'(pkt_cnt_o), '0);
    $display("t5 random done rx_beats=%0d", rx_beats - base_rx);

    // 6: async reset mid-packet and mid-output, then normal traffic
    ready_mode = 0;
    step(); step();
    send_pkt(4, 1'b1);
    repeat (4) step();
    check_eq("t6_valid_before", PKT_W'(pkt_out_valid), PKT_W'(1));
    send_beat(PKT_HEAD, 132'h30);
    send_beat(PKT_BODY, 132'h31);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", PKT_W'(pkt_out_valid), '0);
    check_eq("t6_rst_data", pkt_out, '0);
    check_eq("t6_rst_pkt_cnt", PKT_W'(pkt_cnt_o), '0);
    check_eq("t6_rst_drop_cnt", PKT_W'(drop_cnt_o), '0);
    check_eq("t6_rst_pulse", PKT_W'(drop_pulse_o), '0);
    exp_q.delete();
    exp_drops = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    ready_mode = 1;
    step(); step();
    base_rx = rx_beats;
    send_pkt(3, 1'b1);
    drain(200);
    check_eq("t6_rx_beats", PKT_W'(rx_beats - base_rx), PKT_W'(3));
    check_eq("t6_drop_cnt", PKT_W'(drop_cnt_o), PKT_W'(exp_drops));
    $display("t6 reset recovery done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
